// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared arithmetic_logic_system.
// Grants one requester, holds its operands steady for WAIT_CYC edges while the
// (registered) ALU settles, captures ALUout/AltB, then pulses that requester's done.
// Optional macro ALU_ARB_RR_EN: round-robin arbitration between simultaneous
// requests; without it requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] imm0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic [15:0] imm1,
    input  logic        src0,
    input  logic        src1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        altb,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] alu_imm,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        alu_altb
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYC - 1);

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_a, r_b, r_imm, r_result;
    logic        r_src, r_altb;
    logic [2:0]  r_op;
    logic        r_gnt0, r_gnt1, r_done0, r_done1;
    logic        r_id;       // requester owning the operation in flight
    logic        w_any_req;
    logic        w_win1;     // requester 1 wins this arbitration

    assign w_any_req = req0 | req1;

`ifdef ALU_ARB_RR_EN
    logic r_last;            // last granted requester; reset to 1 so 0 wins first

    // Round-robin pointer: only moves when a grant is actually issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= 1'b1;
        else if (r_state == S_IDLE && w_any_req)
            r_last <= w_win1;
    end

    assign w_win1 = req1 & (~req0 | ~r_last);
`else
    assign w_win1 = req1 & ~req0;
`endif

    // Arbitration FSM, operand capture, result capture and pulse generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_src    <= 1'b0;
            r_op     <= '0;
            r_id     <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_result <= '0;
            r_altb   <= 1'b0;
        end else begin
            // pulses default low; set only on the edge that starts them
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_id   <= w_win1;
                        r_gnt0 <= ~w_win1;
                        r_gnt1 <= w_win1;
                        r_a    <= w_win1 ? a1   : a0;
                        r_b    <= w_win1 ? b1   : b0;
                        r_imm  <= w_win1 ? imm1 : imm0;
                        r_src  <= w_win1 ? src1 : src0;
                        r_op   <= w_win1 ? op1  : op0;
                        r_cnt  <= CNT_LOAD;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 3'd0) begin
                        r_result <= alu_out;
                        r_altb   <= alu_altb;
                        r_done0  <= ~r_id;
                        r_done1  <= r_id;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign result  = r_result;
    assign altb    = r_altb;
    assign alu_a   = r_a;
    assign alu_b   = r_b;
    assign alu_imm = r_imm;
    assign alu_src = r_src;
    assign alu_op  = r_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (WAIT_CYC=2) with a registered ALU model.
// Arbitration expectations follow ALU_ARB_RR_EN when it is defined.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] a0, b0, imm0, a1, b1, imm1;
    logic        src0, src1;
    logic [2:0]  op0, op1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] result;
    logic        altb;
    logic [15:0] alu_a, alu_b, alu_imm;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_altb;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SLT = 3'b101;

    always #5 clk = ~clk;

    alu_arbiter #(.WAIT_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .imm0(imm0),
        .a1(a1), .b1(b1), .imm1(imm1),
        .src0(src0), .src1(src1), .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .altb(altb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
        .alu_src(alu_src), .alu_op(alu_op),
        .alu_out(alu_out), .alu_altb(alu_altb)
    );

    // Registered ALU model: src=1 selects B, src=0 selects Imm
    logic [15:0] m_b;
    assign m_b = alu_src ? alu_b : alu_imm;
    always_ff @(posedge clk) begin
        alu_altb <= $signed(alu_a) < $signed(m_b);
        case (alu_op)
            3'b000:  alu_out <= alu_a + m_b;
            3'b001:  alu_out <= alu_a - m_b;
            3'b010:  alu_out <= alu_a & m_b;
            3'b011:  alu_out <= alu_a | m_b;
            3'b100:  alu_out <= alu_a ^ m_b;
            3'b101:  alu_out <= {15'd0, $signed(alu_a) < $signed(m_b)};
            default: alu_out <= 16'd0;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; imm0 = 0; a1 = 0; b1 = 0; imm1 = 0;
        src0 = 0; src1 = 0; op0 = 0; op1 = 0;
        #3;
        checks++;
        if ({gnt0, gnt1, done0, done1, result, altb, alu_a, alu_b, alu_imm, alu_src, alu_op} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b%b done=%b%b res=%h alu_a=%h exp all zero",
                     gnt0, gnt1, done0, done1, result, alu_a);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_op;
        @(negedge clk);
        req0 = 1; a0 = 16'h0005; b0 = 16'h0003; src0 = 1; op0 = OP_ADD;
        tick;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || alu_a !== 16'h0005) begin
            errors++;
            $display("FAIL single_grant got gnt0=%b gnt1=%b alu_a=%h exp 1 0 0005", gnt0, gnt1, alu_a);
        end
        req0 = 0;
        tick;
        checks++;
        if (gnt0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL single_exec got gnt0=%b done0=%b exp 0 0", gnt0, done0);
        end
        tick;
        checks++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || result !== 16'h0008 || altb !== 1'b0) begin
            errors++;
            $display("FAIL single_done got done0=%b done1=%b result=%h altb=%b exp 1 0 0008 0",
                     done0, done1, result, altb);
        end
        tick;
        checks++;
        if (done0 !== 1'b0 || result !== 16'h0008) begin
            errors++;
            $display("FAIL single_hold got done0=%b result=%h exp 0 0008", done0, result);
        end
    endtask

    task automatic test_operand_hold;
        @(negedge clk);
        req0 = 1; a0 = 16'h0005; b0 = 16'h0003; src0 = 1; op0 = OP_ADD;
        tick;
        a0 = 16'hFFFF;
        req0 = 0;
        tick;
        tick;
        checks++;
        if (done0 !== 1'b1 || result !== 16'h0008 || alu_a !== 16'h0005) begin
            errors++;
            $display("FAIL operand_hold got done0=%b result=%h alu_a=%h exp 1 0008 0005",
                     done0, result, alu_a);
        end
        tick;
        a0 = 16'h0005;
    endtask

    task automatic test_imm_slt;
        @(negedge clk);
        req1 = 1; a1 = 16'h0002; imm1 = 16'h0007; b1 = 16'h0009; src1 = 0; op1 = OP_SLT;
        tick;
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || alu_imm !== 16'h0007 || alu_src !== 1'b0 || alu_op !== OP_SLT) begin
            errors++;
            $display("FAIL imm_grant got gnt1=%b gnt0=%b imm=%h src=%b op=%b exp 1 0 0007 0 101",
                     gnt1, gnt0, alu_imm, alu_src, alu_op);
        end
        req1 = 0;
        tick;
        tick;
        checks++;
        if (done1 !== 1'b1 || done0 !== 1'b0 || altb !== 1'b1 || result !== 16'h0001) begin
            errors++;
            $display("FAIL imm_slt got done1=%b done0=%b altb=%b result=%h exp 1 0 1 0001",
                     done1, done0, altb, result);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int gidx[$];
        @(negedge clk);
        req0 = 1; a0 = 16'h0010; b0 = 16'h0001; src0 = 1; op0 = OP_ADD;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (gnt0) gidx.push_back(i);
        end
        @(negedge clk);
        req0 = 0;
        checks++;
        if (gidx.size() != 2 || gidx[0] != 0 || gidx[1] != 4) begin
            errors++;
            $display("FAIL back_to_back grants=%0d first=%0d second=%0d exp 2 0 4",
                     gidx.size(), gidx.size() > 0 ? gidx[0] : -1, gidx.size() > 1 ? gidx[1] : -1);
        end
        checks++;
        if (result !== 16'h0011) begin
            errors++;
            $display("FAIL back_to_back_result got %h exp 0011", result);
        end
    endtask

    task automatic test_arbitration;
        logic [3:0] order;
        logic [3:0] exp_order;
        int n = 0;
        int nd0 = 0;
        int nd1 = 0;
        int overlap = 0;
        order = '0;
`ifdef ALU_ARB_RR_EN
        exp_order = 4'b1010;   // bit i = requester of grant i: 0,1,0,1
`else
        exp_order = 4'b0000;
`endif
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        req0 = 1; a0 = 16'h0001; b0 = 16'h0001; src0 = 1; op0 = OP_ADD;
        req1 = 1; a1 = 16'h0002; b1 = 16'h0002; src1 = 1; op1 = OP_ADD;
        for (int i = 0; i < 16; i++) begin
            tick;
            if ((gnt0 & gnt1) | (done0 & done1)) overlap++;
            if (gnt0 || gnt1) begin
                if (n < 4) order[n] = gnt1;
                n++;
            end
            if (done0) nd0++;
            if (done1) nd1++;
        end
        @(negedge clk);
        req0 = 0; req1 = 0;
        checks++;
        if (n != 4 || order !== exp_order) begin
            errors++;
            $display("FAIL arb_order grants=%0d order=%b exp 4 %b", n, order, exp_order);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL arb_overlap got %0d exp 0", overlap);
        end
        checks++;
`ifdef ALU_ARB_RR_EN
        if (nd0 != 2 || nd1 != 2) begin
            errors++;
            $display("FAIL arb_dones got d0=%0d d1=%0d exp 2 2", nd0, nd1);
        end
`else
        if (nd0 != 4 || nd1 != 0) begin
            errors++;
            $display("FAIL arb_dones got d0=%0d d1=%0d exp 4 0", nd0, nd1);
        end
`endif
    endtask

    task automatic test_async_reset;
        int spurious = 0;
        @(negedge clk);
        req0 = 1; a0 = 16'h0005; b0 = 16'h0003; src0 = 1; op0 = OP_ADD;
        tick;
        req0 = 0;
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, result, altb, alu_a, alu_b, alu_imm, alu_src, alu_op} !== '0) begin
            errors++;
            $display("FAIL async_reset got gnt=%b%b done=%b%b res=%h alu_a=%h alu_b=%h exp all zero",
                     gnt0, gnt1, done0, done1, result, alu_a, alu_b);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (done0 || done1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL async_no_done got %0d pulses exp 0", spurious);
        end
        @(negedge clk);
        req0 = 1; a0 = 16'h0001; b0 = 16'h0001;
        tick;
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL async_idle_regrant got gnt0=%b exp 1", gnt0);
        end
        req0 = 0;
        tick;
        tick;
        checks++;
        if (done0 !== 1'b1 || result !== 16'h0002) begin
            errors++;
            $display("FAIL async_after_op got done0=%b result=%h exp 1 0002", done0, result);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_single_op;
        test_operand_hold;
        test_imm_slt;
        test_back_to_back;
        test_arbitration;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
